// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer and HI/LO register file for the E stage.
// Optional madd/msub support is enabled by defining MDU_MADD_EN.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_mdOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        req,
  input  logic        D_is_md,
  output logic [31:0] md_out,
  output logic        start,
  output logic        busy,
  output logic        stall_md
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
`endif

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [31:0] hi, lo;
  logic [31:0] pend_hi, pend_lo;
  logic [3:0]  cnt;

  logic        launch;
  logic        is_div;
  logic [63:0] res;
  logic [63:0] sprod, uprod;
  logic signed [32:0] sa, sb;
  logic [31:0] sq, sr, uq, ur;

  assign sprod = 64'($signed({{32{E_A[31]}}, E_A})
               * $signed({{32{E_B[31]}}, E_B}));
  assign uprod = {32'b0, E_A} * {32'b0, E_B};

  // 33-bit signed divide keeps 0x80000000 / -1 well defined
  assign sa = {E_A[31], E_A};
  assign sb = {E_B[31], E_B};
  assign sq = 32'(sa / sb);
  assign sr = 32'(sa % sb);
  assign uq = E_A / E_B;
  assign ur = E_A % E_B;

  always_comb begin
    launch = 1'b0;
    is_div = 1'b0;
    res    = 64'b0;
    case (E_mdOp)
      OP_MULT: begin
        launch = 1'b1;
        res    = sprod;
      end
      OP_MULTU: begin
        launch = 1'b1;
        res    = uprod;
      end
      OP_DIV: begin
        launch = 1'b1;
        is_div = 1'b1;
        res    = (E_B == 32'b0) ? {E_A, 32'hFFFF_FFFF}
                                : {sr, sq};
      end
      OP_DIVU: begin
        launch = 1'b1;
        is_div = 1'b1;
        res    = (E_B == 32'b0) ? {E_A, 32'hFFFF_FFFF}
                                : {ur, uq};
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        launch = 1'b1;
        res    = {hi, lo} + sprod;
      end
      OP_MSUB: begin
        launch = 1'b1;
        res    = {hi, lo} - sprod;
      end
`endif
      default: ;
    endcase
  end

  assign busy     = (cnt != 4'd0);
  assign start    = launch & ~busy & ~req;
  assign stall_md = D_is_md & (start | busy);

  always_comb begin
    md_out = 32'b0;
    if (E_mdOp == OP_MFHI) md_out = hi;
    if (E_mdOp == OP_MFLO) md_out = lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= 32'b0;
      lo      <= 32'b0;
      pend_hi <= 32'b0;
      pend_lo <= 32'b0;
      cnt     <= 4'd0;
    end else if (start) begin
      pend_hi <= res[63:32];
      pend_lo <= res[31:0];
      cnt     <= is_div ? DIV_N : MULT_N;
    end else if (busy) begin
      // an in-flight op ignores req and always commits
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (!req) begin
      if (E_mdOp == OP_MTHI) hi <= E_A;
      if (E_mdOp == OP_MTLO) lo <= E_A;
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed vector bench for md_unit_ctrl.
// Expected values track MDU_MADD_EN when it is defined.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_mdOp;
  logic [31:0] E_A, E_B;
  logic        req, D_is_md;
  logic [31:0] md_out;
  logic        start, busy, stall_md;

  int checks = 0;
  int errors = 0;

  md_unit_ctrl dut (
    .clk(clk), .reset(reset), .E_mdOp(E_mdOp),
    .E_A(E_A), .E_B(E_B), .req(req), .D_is_md(D_is_md),
    .md_out(md_out), .start(start), .busy(busy),
    .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rq;
    logic        e_start;
    int          e_busy;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  vec_t v[17];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic read_hilo(input string nm, input logic [31:0] ehi,
                           input logic [31:0] elo);
    D_is_md = 1'b0;
    E_mdOp  = 4'd7;
    #1;
    check({nm, " hi"}, md_out, ehi);
    check({nm, " nostall"}, {31'b0, stall_md}, 32'd0);
    E_mdOp = 4'd8;
    #1;
    check({nm, " lo"}, md_out, elo);
    E_mdOp = 4'd0;
  endtask

  task automatic run_vec(input vec_t t);
    int n;
    int st;
    @(negedge clk);
    E_mdOp  = t.op;
    E_A     = t.a;
    E_B     = t.b;
    req     = t.rq;
    D_is_md = 1'b1;
    #1;
    check({t.name, " start"}, {31'b0, start}, {31'b0, t.e_start});
    st = int'(stall_md);
    @(negedge clk);
    E_mdOp = 4'd0;
    req    = 1'b0;
    #1;
    n = 0;
    while (busy && n < 20) begin
      n++;
      st += int'(stall_md);
      @(negedge clk);
      #1;
    end
    check({t.name, " busy_cycles"}, 32'(n), 32'(t.e_busy));
    check({t.name, " stall_cycles"}, 32'(st),
          32'(t.e_busy) + {31'b0, t.e_start});
    read_hilo(t.name, t.e_hi, t.e_lo);
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b, input logic rq,
      input logic es, input int eb, input logic [31:0] eh,
      input logic [31:0] el);
    vec_t t;
    t.name = nm; t.op = op; t.a = a; t.b = b; t.rq = rq;
    t.e_start = es; t.e_busy = eb; t.e_hi = eh; t.e_lo = el;
    return t;
  endfunction

  initial begin
    int n;
    v[0]  = mk("mult_m3x7", 4'd1, 32'hFFFF_FFFD, 32'd7, 1'b0,
               1'b1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    v[1]  = mk("multu_max", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0,
               1'b1, 5, 32'h1, 32'hFFFF_FFFE);
    v[2]  = mk("divu_100_7", 4'd4, 32'd100, 32'd7, 1'b0,
               1'b1, 10, 32'd2, 32'd14);
    v[3]  = mk("div_m7_2", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0,
               1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    v[4]  = mk("div_by0", 4'd3, 32'd5, 32'd0, 1'b0,
               1'b1, 10, 32'd5, 32'hFFFF_FFFF);
    v[5]  = mk("divu_by0", 4'd4, 32'd9, 32'd0, 1'b0,
               1'b1, 10, 32'd9, 32'hFFFF_FFFF);
    v[6]  = mk("mult_req", 4'd1, 32'd3, 32'd3, 1'b1,
               1'b0, 0, 32'd9, 32'hFFFF_FFFF);
    v[7]  = mk("mtlo_req", 4'd6, 32'h1234, 32'd0, 1'b1,
               1'b0, 0, 32'd9, 32'hFFFF_FFFF);
    v[8]  = mk("mthi", 4'd5, 32'hABCD, 32'd0, 1'b0,
               1'b0, 0, 32'hABCD, 32'hFFFF_FFFF);
    v[9]  = mk("mtlo", 4'd6, 32'h1234, 32'd0, 1'b0,
               1'b0, 0, 32'hABCD, 32'h1234);
    v[10] = mk("div_7_m2", 4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0,
               1'b1, 10, 32'd1, 32'hFFFF_FFFD);
    v[11] = mk("mthi0", 4'd5, 32'd0, 32'd0, 1'b0,
               1'b0, 0, 32'd0, 32'hFFFF_FFFD);
    v[12] = mk("mtlo1", 4'd6, 32'd1, 32'd0, 1'b0,
               1'b0, 0, 32'd0, 32'd1);
`ifdef MDU_MADD_EN
    v[13] = mk("madd", 4'd9, 32'd2, 32'd3, 1'b0,
               1'b1, 5, 32'd0, 32'd7);
    v[14] = mk("msub", 4'd10, 32'd1, 32'd3, 1'b0,
               1'b1, 5, 32'd0, 32'd4);
    v[15] = mk("nop15", 4'd15, 32'd5, 32'd5, 1'b0,
               1'b0, 0, 32'd0, 32'd4);
`else
    v[13] = mk("madd_off", 4'd9, 32'd2, 32'd3, 1'b0,
               1'b0, 0, 32'd0, 32'd1);
    v[14] = mk("msub_off", 4'd10, 32'd1, 32'd3, 1'b0,
               1'b0, 0, 32'd0, 32'd1);
    v[15] = mk("nop15", 4'd15, 32'd5, 32'd5, 1'b0,
               1'b0, 0, 32'd0, 32'd1);
`endif
    v[16] = mk("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
               1'b1, 10, 32'd0, 32'h8000_0000);

    reset = 1'b1; E_mdOp = 4'd0; E_A = '0; E_B = '0;
    req = 1'b0; D_is_md = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst start", {31'b0, start}, 32'd0);
    check("rst stall", {31'b0, stall_md}, 32'd0);
    read_hilo("rst", 32'd0, 32'd0);

    for (int i = 0; i < 17; i++) run_vec(v[i]);

    // req during busy must not abort the op
    @(negedge clk);
    E_mdOp = 4'd1; E_A = 32'd4; E_B = 32'd5; D_is_md = 1'b0;
    @(negedge clk);
    E_mdOp = 4'd0; req = 1'b1;
    #1;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    req = 1'b0;
    check("req_busy cycles", 32'(n), 32'd5);
    read_hilo("req_busy", 32'd0, 32'd20);

    // reset in the middle of a div discards it
    @(negedge clk);
    E_mdOp = 4'd5; E_A = 32'h55;
    @(negedge clk);
    E_mdOp = 4'd4; E_A = 32'd100; E_B = 32'd7;
    @(negedge clk);
    E_mdOp = 4'd0;
    #1;
    check("rst_mid busy1", {31'b0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid busy", {31'b0, busy}, 32'd0);
    read_hilo("rst_mid", 32'd0, 32'd0);
    repeat (12) @(negedge clk);
    #1;
    check("rst_mid late busy", {31'b0, busy}, 32'd0);
    read_hilo("rst_mid late", 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
